// File: rtl/pmod_axi_master.sv
// AXI4 master back end for the PMOD command decoder: one outstanding transaction,
// single-beat writes and 1-128 beat INCR reads with a per-beat consumer handshake.
module pmod_axi_master #(
  parameter int unsigned ID_W = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            write_req,
  input  logic            read_req,
  input  logic [9:0]      len,
  input  logic [31:0]     address,
  input  logic [63:0]     wdata,
  input  logic            rnext,
  output logic            busy,
  output logic [63:0]     rdata,
  output logic            rlast,
  output logic            err,
  output logic [ID_W-1:0] m_awid,
  output logic [31:0]     m_awaddr,
  output logic [7:0]      m_awlen,
  output logic [2:0]      m_awsize,
  output logic [1:0]      m_awburst,
  output logic            m_awvalid,
  input  logic            m_awready,
  output logic [63:0]     m_wdata,
  output logic [7:0]      m_wstrb,
  output logic            m_wlast,
  output logic            m_wvalid,
  input  logic            m_wready,
  input  logic [ID_W-1:0] m_bid,
  input  logic [1:0]      m_bresp,
  input  logic            m_bvalid,
  output logic            m_bready,
  output logic [ID_W-1:0] m_arid,
  output logic [31:0]     m_araddr,
  output logic [7:0]      m_arlen,
  output logic [2:0]      m_arsize,
  output logic [1:0]      m_arburst,
  output logic            m_arvalid,
  input  logic            m_arready,
  input  logic [ID_W-1:0] m_rid,
  input  logic [63:0]     m_rdata,
  input  logic [1:0]      m_rresp,
  input  logic            m_rlast,
  input  logic            m_rvalid,
  output logic            m_rready
);

  typedef enum logic [2:0] {IDLE, WADDR, WRESP, RADDR, RDATA, RHOLD} state_e;

  state_e      state_q;
  logic        busy_q, err_q, rlast_q;
  logic [63:0] rdata_q, wdata_q;
  logic [31:0] awaddr_q, araddr_q;
  logic [7:0]  awlen_q, arlen_q, wstrb_q;
  logic [2:0]  awsize_q, arsize_q;
  logic        awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;

  logic        burst_d;
  logic [2:0]  size_d;
  logic [7:0]  mask_d;
  logic [15:0] strb_wide_d;

  // Size code 000 decodes as 8 bytes: a burst for reads, a single 8-byte beat for writes.
  always_comb begin
    burst_d = (len[2:0] == 3'b000);
    casez (len[2:0])
      3'b11?:  size_d = 3'd3;
      3'b1??:  size_d = 3'd2;
      3'b?1?:  size_d = 3'd1;
      3'b001:  size_d = 3'd0;
      default: size_d = 3'd3;
    endcase
    case (size_d)
      3'd0:    mask_d = 8'h01;
      3'd1:    mask_d = 8'h03;
      3'd2:    mask_d = 8'h0F;
      default: mask_d = 8'hFF;
    endcase
    strb_wide_d = {8'h00, mask_d} << address[2:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      rlast_q   <= 1'b0;
      rdata_q   <= '0;
      wdata_q   <= '0;
      awaddr_q  <= '0;
      araddr_q  <= '0;
      awlen_q   <= '0;
      arlen_q   <= '0;
      wstrb_q   <= '0;
      awsize_q  <= '0;
      arsize_q  <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (write_req) begin
            state_q   <= WADDR;
            awaddr_q  <= address;
            awlen_q   <= '0;
            awsize_q  <= size_d;
            wdata_q   <= wdata;
            wstrb_q   <= strb_wide_d[7:0];
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            busy_q    <= 1'b1;
            err_q     <= 1'b0;
          end else if (read_req) begin
            state_q   <= RADDR;
            araddr_q  <= burst_d ? {address[31:3], 3'b000} : address;
            arlen_q   <= burst_d ? {1'b0, len[9:3]} : '0;
            arsize_q  <= size_d;
            arvalid_q <= 1'b1;
            busy_q    <= 1'b1;
            err_q     <= 1'b0;
          end
        end
        WADDR: begin
          if (m_awready) awvalid_q <= 1'b0;
          if (m_wready)  wvalid_q  <= 1'b0;
          // AW and W complete independently; move on once neither is still pending.
          if ((!awvalid_q || m_awready) && (!wvalid_q || m_wready)) begin
            state_q  <= WRESP;
            bready_q <= 1'b1;
          end
        end
        WRESP: begin
          if (m_bvalid) begin
            state_q  <= IDLE;
            bready_q <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= err_q | (m_bresp != 2'b00);
          end
        end
        RADDR: begin
          if (m_arready) begin
            state_q   <= RDATA;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
          end
        end
        RDATA: begin
          if (m_rvalid) begin
            state_q  <= m_rlast ? IDLE : RHOLD;
            rdata_q  <= m_rdata;
            rlast_q  <= m_rlast;
            rready_q <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= err_q | (m_rresp != 2'b00);
          end
        end
        RHOLD: begin
          if (rnext) begin
            state_q  <= RDATA;
            rready_q <= 1'b1;
            busy_q   <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  logic unused_ids;
  assign unused_ids = &{1'b0, m_bid, m_rid};

  assign busy      = busy_q;
  assign rdata     = rdata_q;
  assign rlast     = rlast_q;
  assign err       = err_q;
  assign m_awid    = '0;
  assign m_awaddr  = awaddr_q;
  assign m_awlen   = awlen_q;
  assign m_awsize  = awsize_q;
  assign m_awburst = 2'b01;
  assign m_awvalid = awvalid_q;
  assign m_wdata   = wdata_q;
  assign m_wstrb   = wstrb_q;
  assign m_wlast   = 1'b1;
  assign m_wvalid  = wvalid_q;
  assign m_bready  = bready_q;
  assign m_arid    = '0;
  assign m_araddr  = araddr_q;
  assign m_arlen   = arlen_q;
  assign m_arsize  = arsize_q;
  assign m_arburst = 2'b01;
  assign m_arvalid = arvalid_q;
  assign m_rready  = rready_q;

endmodule
